modulo_entrada: RTL and testbench

Input-side unit for the multicycle processor: the counterpart of the display output path, delivering operator data into the datapath. It synchronizes the 9-bit switch bank and the raw `enter` push-button, debounces `enter`, and captures one switch word per press. The captured word is handed to the control unit through a request/ready handshake, replacing the bare `dadosIN`/`enter` inputs now wired into `MuxIn` and `ctrl_undd`. It runs in the divided `clk` domain.

---
 rtl/modulo_entrada_pkg.sv | 15 +
 rtl/modulo_entrada_debouncer.sv | 50 +++++
 rtl/modulo_entrada.sv | 80 ++++++++
 tb/tb_modulo_entrada.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/modulo_entrada_pkg.sv
// Shared types and widths for the operator input unit.
package modulo_entrada_pkg;

   localparam int unsigned LARGURA_SW    = 9;
   localparam int unsigned LARGURA_DADOS = 32;

   // Handshake FSM states, also shown on the debug LEDs
   typedef enum logic [1:0] {
      OCIOSO  = 2'd0,
      AGUARDA = 2'd1,
      ENTREGA = 2'd2,
      SOLTA   = 2'd3
   } estadoEnt_t;

endpackage

// File: rtl/modulo_entrada_debouncer.sv
// Synchronizes and debounces the raw enter key; produces a stable level and its rising pulse.
module modulo_entrada_debouncer #(
   parameter int unsigned DEBOUNCE_CYCLES  = 16,
   parameter bit          ENTER_ACTIVE_LOW = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic enter,
   output logic deb,
   output logic debRise
);

   localparam int unsigned    CNT_W      = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   // Raw level of a released key, so reset never looks like a press
   localparam logic           IDLE_LEVEL = ENTER_ACTIVE_LOW;

   logic [1:0]       syncFf;
   logic             press;
   logic [CNT_W-1:0] cnt;

   // Two-flop synchronizer for the asynchronous key
   always_ff @(posedge clk or posedge rst) begin
      if (rst) syncFf <= {2{IDLE_LEVEL}};
      else     syncFf <= {syncFf[0], enter};
   end

   assign press = ENTER_ACTIVE_LOW ? ~syncFf[1] : syncFf[1];

   // Accept a new level only after DEBOUNCE_CYCLES consecutive disagreeing samples
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt     <= '0;
         deb     <= 1'b0;
         debRise <= 1'b0;
      end else begin
         debRise <= 1'b0;
         if (press == deb) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            cnt     <= '0;
            deb     <= press;
            debRise <= press;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/modulo_entrada.sv
// Operator input unit: captures one switch word per debounced press and hands it over via pedido/pronto.
module modulo_entrada
   import modulo_entrada_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES  = 16,
   parameter bit          ENTER_ACTIVE_LOW = 1'b1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     enter,
   input  logic [LARGURA_SW-1:0]    dadosIN,
   input  logic                     pedido,
   output logic [LARGURA_DADOS-1:0] dados,
   output logic                     pronto,
   output logic [1:0]               estado_ent
);

   logic [LARGURA_SW-1:0] swSync1;
   logic [LARGURA_SW-1:0] swSync2;
   logic                  deb;
   logic                  debRise;
   estadoEnt_t            estado;

   modulo_entrada_debouncer #(
      .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
      .ENTER_ACTIVE_LOW (ENTER_ACTIVE_LOW)
   ) uDebouncer (
      .clk     (clk),
      .rst     (rst),
      .enter   (enter),
      .deb     (deb),
      .debRise (debRise)
   );

   // Two-flop synchronizer for the switch bank
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         swSync1 <= '0;
         swSync2 <= '0;
      end else begin
         swSync1 <= dadosIN;
         swSync2 <= swSync1;
      end
   end

   // Handshake FSM with registered pronto/dados; a held key must be released before it counts again
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         estado <= OCIOSO;
         pronto <= 1'b0;
         dados  <= '0;
      end else begin
         pronto <= 1'b0;
         case (estado)
            OCIOSO: begin
               if (pedido) estado <= deb ? SOLTA : AGUARDA;
            end
            AGUARDA: begin
               if (!pedido) begin
                  estado <= OCIOSO;
               end else if (debRise) begin
                  dados  <= LARGURA_DADOS'(swSync2);
                  pronto <= 1'b1;
                  estado <= ENTREGA;
               end
            end
            ENTREGA: begin
               estado <= SOLTA;
            end
            SOLTA: begin
               if (!deb) estado <= pedido ? AGUARDA : OCIOSO;
            end
            default: estado <= OCIOSO;
         endcase
      end
   end

   assign estado_ent = estado;

endmodule

// File: tb/tb_modulo_entrada.sv
// Scoreboard bench for modulo_entrada with a short debounce window.
module tb_modulo_entrada;

   localparam int unsigned DC = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        enter;
   logic [8:0]  dadosIN;
   logic        pedido;
   logic [31:0] dados;
   logic        pronto;
   logic [1:0]  estado_ent;

   typedef struct {
      logic [31:0] data;
      int          cyc;
   } esperado_t;

   esperado_t sb[$];
   esperado_t ent;
   int        cyc = 0;
   int        checks = 0;
   int        errors = 0;
   logic      expP;

   modulo_entrada #(
      .DEBOUNCE_CYCLES  (DC),
      .ENTER_ACTIVE_LOW (1'b1)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .enter      (enter),
      .dadosIN    (dadosIN),
      .pedido     (pedido),
      .dados      (dados),
      .pronto     (pronto),
      .estado_ent (estado_ent)
   );

   always #5 clk = ~clk;

   task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] esp);
      checks++;
      if (obs !== esp) begin
         errors++;
         $display("FAIL %s cycle %0d observed %h expected %h", tag, cyc, obs, esp);
      end
   endtask

   // Raw press sampled at the next edge E0 yields pronto after E0+DC+2
   task automatic esperaCaptura(input logic [8:0] sw);
      esperado_t e;
      e.data = 32'(sw);
      e.cyc  = cyc + 1 + DC + 2;
      sb.push_back(e);
   endtask

   task automatic ciclos(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Every cycle: pronto must match the scoreboard; on a hit compare the delivered word
   always @(posedge clk) begin
      cyc = cyc + 1;
      #1;
      expP = (sb.size() > 0) && (sb[0].cyc == cyc);
      checkVal("pronto", 32'(pronto), 32'(expP));
      if (expP) begin
         ent = sb.pop_front();
         checkVal("dados_pronto", dados, ent.data);
      end
   end

   initial begin
      rst     = 1'b1;
      enter   = 1'b1;
      pedido  = 1'b0;
      dadosIN = 9'h000;
      ciclos(3);
      checkVal("reset_dados", dados, 32'h0);
      checkVal("reset_estado", 32'(estado_ent), 32'd0);
      rst = 1'b0;
      ciclos(2);

      // 1: clean press
      pedido  = 1'b1;
      dadosIN = 9'h1A5;
      ciclos(3);
      checkVal("t1_aguarda", 32'(estado_ent), 32'd1);
      @(negedge clk); enter = 1'b0; esperaCaptura(9'h1A5);
      ciclos(12);
      checkVal("t1_solta", 32'(estado_ent), 32'd3);
      checkVal("t1_dados", dados, 32'h000001A5);
      @(negedge clk); enter = 1'b1;
      ciclos(10);
      checkVal("t1_volta_aguarda", 32'(estado_ent), 32'd1);

      // 2: bouncing key, only the final settled press counts
      for (int i = 0; i < 11; i++) begin
         @(negedge clk);
         enter = (i % 2 == 1);
         if (i == 10) esperaCaptura(9'h1A5);
         @(negedge clk);
      end
      ciclos(12);
      checkVal("t2_solta", 32'(estado_ent), 32'd3);
      @(negedge clk); enter = 1'b1;
      ciclos(10);
      checkVal("t2_aguarda", 32'(estado_ent), 32'd1);

      // 3: presses without a request are ignored and not buffered
      dadosIN = 9'h055;
      @(negedge clk); pedido = 1'b0;
      ciclos(2);
      checkVal("t3_ocioso", 32'(estado_ent), 32'd0);
      @(negedge clk); enter = 1'b0;
      ciclos(12);
      @(negedge clk); enter = 1'b1;
      ciclos(12);
      checkVal("t3_dados_mantidos", dados, 32'h000001A5);
      @(negedge clk); pedido = 1'b1;
      ciclos(20);
      checkVal("t3_aguarda", 32'(estado_ent), 32'd1);

      // 4: key already held when the request arrives
      @(negedge clk); pedido = 1'b0;
      ciclos(2);
      @(negedge clk); enter = 1'b0;
      ciclos(12);
      @(negedge clk); pedido = 1'b1;
      ciclos(2);
      checkVal("t4_solta", 32'(estado_ent), 32'd3);
      @(negedge clk); enter = 1'b1;
      ciclos(10);
      checkVal("t4_aguarda", 32'(estado_ent), 32'd1);
      dadosIN = 9'h0FF;
      ciclos(3);
      @(negedge clk); enter = 1'b0; esperaCaptura(9'h0FF);
      ciclos(12);
      checkVal("t4_dados", dados, 32'h000000FF);
      @(negedge clk); enter = 1'b1;
      ciclos(10);

      // 5: abort from AGUARDA, then reset in the middle of ENTREGA
      @(negedge clk); pedido = 1'b0;
      ciclos(2);
      checkVal("t5_abort_ocioso", 32'(estado_ent), 32'd0);
      checkVal("t5_abort_dados", dados, 32'h000000FF);
      @(negedge clk); pedido = 1'b1;
      ciclos(2);
      checkVal("t5_aguarda", 32'(estado_ent), 32'd1);
      dadosIN = 9'h0AA;
      ciclos(3);
      @(negedge clk); enter = 1'b0; esperaCaptura(9'h0AA);
      repeat (1 + DC + 2) @(posedge clk);
      #3;
      checkVal("t5_entrega", 32'(estado_ent), 32'd2);
      rst = 1'b1;
      #1;
      checkVal("t5_rst_pronto", 32'(pronto), 32'd0);
      checkVal("t5_rst_dados", dados, 32'h0);
      checkVal("t5_rst_estado", 32'(estado_ent), 32'd0);
      pedido = 1'b0;
      ciclos(2);
      rst   = 1'b0;
      enter = 1'b1;
      ciclos(12);
      checkVal("t5_pos_reset", 32'(estado_ent), 32'd0);

      // 6: switch changes outside the capture cycle leave dados alone
      @(negedge clk); pedido = 1'b1;
      dadosIN = 9'h003;
      ciclos(3);
      @(negedge clk); enter = 1'b0; esperaCaptura(9'h003);
      ciclos(12);
      @(negedge clk); enter = 1'b1;
      ciclos(10);
      dadosIN = 9'h1FF;
      ciclos(20);
      checkVal("t6_dados_estaveis", dados, 32'h00000003);
      checkVal("t6_aguarda", 32'(estado_ent), 32'd1);

      checkVal("fila_vazia", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
